imm_decode_stage: RTL and testbench
===================================

IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, immediate width; legal values 32 and 64.
REQ-002 SHALL have parameter NUM_LANES, default 2, instructions per bundle; legal range 1..4.
REQ-003 SHALL have parameter CUSTOM_EN, default 1; when 1, custom opcodes are decoded, and when 0 they decode as NONE.
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 flush_i  input  1  discards all held bundles.
REQ-008 in_valid_i  input  1  bundle offered.
REQ-009 in_ready_o  output  1  bundle can be accepted.
REQ-010 in_inst_i  input  NUM_LANES*32  instructions, lane 0 in the LSBs.
REQ-011 in_lane_en_i  input  NUM_LANES  per-lane valid mask.
REQ-012 out_valid_o  output  1  decoded bundle available.
REQ-013 out_ready_i  input  1  consumer accepts.
REQ-014 out_imm_o  output  NUM_LANES*XLEN  immediates.
REQ-015 out_type_o  output  NUM_LANES*3  imm_type per lane.
REQ-016 out_inst_o / out_lane_en_o  output  NUM_LANES*32 / NUM_LANES  pass-through of the accepted bundle.

Function
REQ-017 Type codes SHALL be: NONE=0, I=1, S=2, B=3, U=4, J=5, CSR=6, SHAMT=7.
REQ-018 Opcode 0x13 with func3 001/101 SHALL be SHAMT: inst[24:20] for XLEN=32 or inst[25:20] for XLEN=64, zero-extended.
REQ-019 Opcode 0x03 SHALL be I with inst[31:20] zero-extended; opcodes 0x13 (other func3), 0x67 and 0x15 SHALL be I with inst[31:20] sign-extended.
REQ-020 Custom opcode 0x14 SHALL be I with inst[31:20] zero-extended.
REQ-021 Opcode 0x73 SHALL be CSR: inst[19:15] zero-extended.
REQ-022 Opcode 0x23 SHALL be S: {inst[31:25],inst[11:7]} sign-extended; func3=011 SHALL yield imm 0 when CUSTOM_EN=1.
REQ-023 Opcodes 0x63, 0x64 and 0x65 SHALL be B: {inst[31],inst[7],inst[30:25],inst[11:8],0} sign-extended.
REQ-024 Opcodes 0x17, 0x37, 0x3B and 0x3C SHALL be U: {inst[31:12],12'b0}, sign-extended from bit 31 to XLEN.
REQ-025 Opcode 0x6F SHALL be J: {inst[31],inst[19:12],inst[20],inst[30:21],0} sign-extended.
REQ-026 Any other opcode, or a lane whose lane_en bit is 0, SHALL give imm 0 and type NONE.
REQ-027 A bundle SHALL be accepted on a cycle where in_valid_i && in_ready_o.
REQ-028 Latency SHALL be 1 cycle: an accepted bundle appears registered on out_* the next cycle if the output register is empty or draining.
REQ-029 Throughput SHALL be one bundle per cycle while out_ready_i=1.
REQ-030 A one-entry skid register SHALL capture an accepted bundle when the output is valid and stalled; in_ready_o SHALL equal !skid_valid, driven from a register.
REQ-031 When the output drains, the skid entry SHALL move to the output before any new bundle, preserving order and losing nothing.
REQ-032 out_* SHALL hold stable while out_valid_o && !out_ready_i.
REQ-033 On flush_i=1, out_valid_o and skid_valid SHALL clear the next cycle, any bundle accepted that cycle SHALL be dropped, and in_ready_o SHALL be 1 the next cycle.
REQ-034 flush_i SHALL take priority over simultaneous accept and drain.

Reset
REQ-035 While rst_n=0, out_valid_o=0, skid_valid=0, in_ready_o=1, and the data registers are 0.
REQ-036 Assertion of rst_n=0 mid-operation SHALL discard all bundles immediately and asynchronously.

Structure
REQ-037 The imm_type enum, opcode constants and XLEN legality check SHALL reside in shared package kira_decode_pkg.
REQ-038 The per-lane combinational decoder SHALL be sub-module imm_lane_decode, instantiated NUM_LANES times; the handshake and skid logic SHALL reside in the top module.

Verification
REQ-039 The bench SHALL cover: lane0 0xFFF00093 (addi -1), XLEN=32 -> next cycle imm 0xFFFFFFFF, type I.
REQ-040 The bench SHALL cover: lane1 0x8000006F (jal) -> imm 0xFFF00000, type J; XLEN=64 -> 0xFFFFFFFFFFF00000.
REQ-041 The bench SHALL cover: XLEN=64, 0x03F09093 (slli 63) -> imm 0x3F, type SHAMT; lane_en=0 on the other lane -> imm 0, type NONE.
REQ-042 The bench SHALL cover: bundles A,B,C offered with out_ready_i=0 for 3 cycles -> A on output, B in skid, in_ready_o=0, C held; after release, output order A,B,C with no loss.
REQ-043 The bench SHALL cover: flush_i pulse with skid full and in_valid_i=1 -> next cycle out_valid_o=0, in_ready_o=1, and the offered bundle never appears.
REQ-044 The bench SHALL cover: rst_n dropped while out_valid_o=1 -> out_valid_o=0 without waiting for a clock edge.

Source files
------------

// File: rtl/kira_decode_pkg.sv
// Shared decode definitions: immediate type codes, opcode constants and
// parameter legality helpers used by the immediate decode stage.
package kira_decode_pkg;

    typedef enum logic [2:0] {
        IMM_NONE  = 3'd0,
        IMM_I     = 3'd1,
        IMM_S     = 3'd2,
        IMM_B     = 3'd3,
        IMM_U     = 3'd4,
        IMM_J     = 3'd5,
        IMM_CSR   = 3'd6,
        IMM_SHAMT = 3'd7
    } imm_type_e;

    localparam logic [6:0] OPC_LOAD      = 7'h03;
    localparam logic [6:0] OPC_OP_IMM    = 7'h13;
    localparam logic [6:0] OPC_CUSTOM    = 7'h14;
    localparam logic [6:0] OPC_OP_IMM_X  = 7'h15;
    localparam logic [6:0] OPC_AUIPC     = 7'h17;
    localparam logic [6:0] OPC_STORE     = 7'h23;
    localparam logic [6:0] OPC_LUI       = 7'h37;
    localparam logic [6:0] OPC_U_X0      = 7'h3B;
    localparam logic [6:0] OPC_U_X1      = 7'h3C;
    localparam logic [6:0] OPC_BRANCH    = 7'h63;
    localparam logic [6:0] OPC_BRANCH_X0 = 7'h64;
    localparam logic [6:0] OPC_BRANCH_X1 = 7'h65;
    localparam logic [6:0] OPC_JALR      = 7'h67;
    localparam logic [6:0] OPC_JAL       = 7'h6F;
    localparam logic [6:0] OPC_SYSTEM    = 7'h73;

    localparam logic [2:0] F3_SLLI   = 3'b001;
    localparam logic [2:0] F3_SRXI   = 3'b101;
    localparam logic [2:0] F3_S_CUST = 3'b011;

    function automatic bit xlen_legal(input int xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

    function automatic bit lanes_legal(input int lanes);
        return (lanes >= 1) && (lanes <= 4);
    endfunction

endpackage

// File: rtl/imm_lane_decode.sv
// Combinational immediate extractor for a single 32-bit instruction lane.
module imm_lane_decode
    import kira_decode_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int CUSTOM_EN = 1
) (
    input  logic [31:0]     inst,
    input  logic            lane_en,
    output logic [XLEN-1:0] imm,
    output imm_type_e       imm_type
);

    logic [6:0] opcode;
    logic [2:0] func3;

    assign opcode = inst[6:0];
    assign func3  = inst[14:12];

    always_comb begin
        imm      = '0;
        imm_type = IMM_NONE;
        if (lane_en) begin
            case (opcode)
                OPC_OP_IMM: begin
                    if (func3 == F3_SLLI || func3 == F3_SRXI) begin
                        imm_type = IMM_SHAMT;
                        // RV64 shift amounts carry one extra bit
                        if (XLEN == 64) imm = XLEN'(inst[25:20]);
                        else            imm = XLEN'(inst[24:20]);
                    end else begin
                        imm_type = IMM_I;
                        imm      = XLEN'(signed'(inst[31:20]));
                    end
                end
                OPC_LOAD: begin
                    imm_type = IMM_I;
                    imm      = XLEN'(inst[31:20]);
                end
                OPC_JALR, OPC_OP_IMM_X: begin
                    imm_type = IMM_I;
                    imm      = XLEN'(signed'(inst[31:20]));
                end
                OPC_CUSTOM: begin
                    if (CUSTOM_EN != 0) begin
                        imm_type = IMM_I;
                        imm      = XLEN'(inst[31:20]);
                    end
                end
                OPC_SYSTEM: begin
                    imm_type = IMM_CSR;
                    imm      = XLEN'(inst[19:15]);
                end
                OPC_STORE: begin
                    imm_type = IMM_S;
                    if (!(CUSTOM_EN != 0 && func3 == F3_S_CUST))
                        imm = XLEN'(signed'({inst[31:25], inst[11:7]}));
                end
                OPC_BRANCH, OPC_BRANCH_X0, OPC_BRANCH_X1: begin
                    imm_type = IMM_B;
                    imm      = XLEN'(signed'({inst[31], inst[7], inst[30:25],
                                              inst[11:8], 1'b0}));
                end
                OPC_AUIPC, OPC_LUI, OPC_U_X0, OPC_U_X1: begin
                    imm_type = IMM_U;
                    imm      = XLEN'(signed'({inst[31:12], 12'b0}));
                end
                OPC_JAL: begin
                    imm_type = IMM_J;
                    imm      = XLEN'(signed'({inst[31], inst[19:12], inst[20],
                                              inst[30:21], 1'b0}));
                end
                default: begin
                    imm      = '0;
                    imm_type = IMM_NONE;
                end
            endcase
        end
    end

endmodule

// File: rtl/imm_decode_stage.sv
// Bundle-wide immediate decode stage: one registered output slot plus a
// one-entry skid buffer so in_ready_o comes straight from a flop.
module imm_decode_stage
    import kira_decode_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int NUM_LANES = 2,
    parameter int CUSTOM_EN = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [NUM_LANES*32-1:0]   in_inst_i,
    input  logic [NUM_LANES-1:0]      in_lane_en_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [NUM_LANES*XLEN-1:0] out_imm_o,
    output logic [NUM_LANES*3-1:0]    out_type_o,
    output logic [NUM_LANES*32-1:0]   out_inst_o,
    output logic [NUM_LANES-1:0]      out_lane_en_o
);

    if (!xlen_legal(XLEN)) begin : g_bad_xlen
        $error("imm_decode_stage: XLEN must be 32 or 64");
    end
    if (!lanes_legal(NUM_LANES)) begin : g_bad_lanes
        $error("imm_decode_stage: NUM_LANES must be 1..4");
    end

    logic [NUM_LANES*XLEN-1:0] dec_imm;
    logic [NUM_LANES*3-1:0]    dec_type;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        imm_type_e lane_type;
        imm_lane_decode #(
            .XLEN      (XLEN),
            .CUSTOM_EN (CUSTOM_EN)
        ) u_dec (
            .inst     (in_inst_i[g*32 +: 32]),
            .lane_en  (in_lane_en_i[g]),
            .imm      (dec_imm[g*XLEN +: XLEN]),
            .imm_type (lane_type)
        );
        assign dec_type[g*3 +: 3] = lane_type;
    end

    logic                      out_valid_q;
    logic                      skid_valid_q;
    logic [NUM_LANES*XLEN-1:0] skid_imm_q;
    logic [NUM_LANES*3-1:0]    skid_type_q;
    logic [NUM_LANES*32-1:0]   skid_inst_q;
    logic [NUM_LANES-1:0]      skid_lane_en_q;

    logic accept;
    logic out_open;

    assign in_ready_o  = !skid_valid_q;
    assign out_valid_o = out_valid_q;
    assign accept      = in_valid_i && in_ready_o;
    assign out_open    = !out_valid_q || out_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (flush_i) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (out_open) begin
            // accept is impossible while the skid is full, so no ordering hazard
            out_valid_q  <= skid_valid_q || accept;
            skid_valid_q <= 1'b0;
        end else if (accept) begin
            skid_valid_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_imm_o      <= '0;
            out_type_o     <= '0;
            out_inst_o     <= '0;
            out_lane_en_o  <= '0;
            skid_imm_q     <= '0;
            skid_type_q    <= '0;
            skid_inst_q    <= '0;
            skid_lane_en_q <= '0;
        end else begin
            if (out_open && skid_valid_q) begin
                out_imm_o     <= skid_imm_q;
                out_type_o    <= skid_type_q;
                out_inst_o    <= skid_inst_q;
                out_lane_en_o <= skid_lane_en_q;
            end else if (out_open && accept) begin
                out_imm_o     <= dec_imm;
                out_type_o    <= dec_type;
                out_inst_o    <= in_inst_i;
                out_lane_en_o <= in_lane_en_i;
            end
            if (!out_open && accept) begin
                skid_imm_q     <= dec_imm;
                skid_type_q    <= dec_type;
                skid_inst_q    <= in_inst_i;
                skid_lane_en_q <= in_lane_en_i;
            end
        end
    end

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench for imm_decode_stage: an XLEN=32 custom-enabled instance and
// an XLEN=64 custom-disabled instance share the same stimulus.
module tb_imm_decode_stage;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush_i;
    logic         in_valid_i;
    logic [63:0]  in_inst_i;
    logic [1:0]   in_lane_en_i;
    logic         out_ready_i;

    logic         rdy32, vld32, rdy64, vld64;
    logic [63:0]  imm32;
    logic [127:0] imm64;
    logic [5:0]   typ32, typ64;
    logic [63:0]  inst32, inst64;
    logic [1:0]   en32, en64;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    imm_decode_stage #(.XLEN(32), .NUM_LANES(2), .CUSTOM_EN(1)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(rdy32),
        .in_inst_i(in_inst_i), .in_lane_en_i(in_lane_en_i),
        .out_valid_o(vld32), .out_ready_i(out_ready_i),
        .out_imm_o(imm32), .out_type_o(typ32),
        .out_inst_o(inst32), .out_lane_en_o(en32)
    );

    imm_decode_stage #(.XLEN(64), .NUM_LANES(2), .CUSTOM_EN(0)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(rdy64),
        .in_inst_i(in_inst_i), .in_lane_en_i(in_lane_en_i),
        .out_valid_o(vld64), .out_ready_i(out_ready_i),
        .out_imm_o(imm64), .out_type_o(typ64),
        .out_inst_o(inst64), .out_lane_en_o(en64)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        if (obs !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] i0, input logic [31:0] i1, input logic [1:0] en);
        in_valid_i   = 1'b1;
        in_inst_i    = {i1, i0};
        in_lane_en_i = en;
    endtask

    task automatic check_vec(input string tag,
                             input logic [31:0] e32_0, input logic [31:0] e32_1,
                             input logic [63:0] e64_0, input logic [63:0] e64_1,
                             input logic [5:0] t32, input logic [5:0] t64);
        chk({tag, " valid"}, {vld32, vld64}, 2'b11);
        chk({tag, " imm32"}, imm32, {e32_1, e32_0});
        chk({tag, " type32"}, typ32, t32);
        chk({tag, " imm64"}, imm64, {e64_1, e64_0});
        chk({tag, " type64"}, typ64, t64);
    endtask

    initial begin
        rst_n        = 1'b0;
        flush_i      = 1'b0;
        in_valid_i   = 1'b0;
        in_inst_i    = '0;
        in_lane_en_i = '0;
        out_ready_i  = 1'b1;
        #2;
        chk("rst valid", {vld32, vld64}, 2'b00);
        chk("rst ready", {rdy32, rdy64}, 2'b11);
        chk("rst imm", {imm64, imm32}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // back-to-back bundles, one per cycle
        drive(32'hFFF00093, 32'h8000006F, 2'b11);
        tick();
        check_vec("addi/jal", 32'hFFFFFFFF, 32'hFFF00000,
                  64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFF00000, 6'b101_001, 6'b101_001);
        chk("addi/jal inst", inst32, {32'h8000006F, 32'hFFF00093});
        drive(32'h03F09093, 32'h8000006F, 2'b01);
        tick();
        check_vec("slli/off", 32'h1F, 32'h0, 64'h3F, 64'h0, 6'b000_111, 6'b000_111);
        chk("slli/off lane_en", en64, 2'b01);
        drive(32'h80002003, 32'h300F9073, 2'b11);
        tick();
        check_vec("lw/csr", 32'h800, 32'h1F, 64'h800, 64'h1F, 6'b110_001, 6'b110_001);
        drive(32'hFE112E23, 32'hFE000EE3, 2'b11);
        tick();
        check_vec("sw/beq", 32'hFFFFFFFC, 32'hFFFFFFFC,
                  64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 6'b011_010, 6'b011_010);
        drive(32'h12345037, 32'hFFFFF017, 2'b11);
        tick();
        check_vec("lui/auipc", 32'h12345000, 32'hFFFFF000,
                  64'h12345000, 64'hFFFFFFFFFFFFF000, 6'b100_100, 6'b100_100);
        drive(32'h80000014, 32'hFE113E23, 2'b11);
        tick();
        check_vec("custom", 32'h800, 32'h0, 64'h0, 64'hFFFFFFFFFFFFFFFC,
                  6'b010_001, 6'b010_000);
        drive(32'h0000007F, 32'hFFF00067, 2'b11);
        tick();
        check_vec("bad/jalr", 32'h0, 32'hFFFFFFFF, 64'h0, 64'hFFFFFFFFFFFFFFFF,
                  6'b001_000, 6'b001_000);
        in_valid_i = 1'b0;
        tick();
        chk("idle valid", {vld32, vld64}, 2'b00);

        // stall with A, B, C offered: A on output, B in skid, C held
        out_ready_i = 1'b0;
        drive(32'h00100093, 32'h0, 2'b01);
        tick();
        chk("A out", inst32[31:0], 32'h00100093);
        chk("A ready", rdy32, 1'b1);
        drive(32'h00200093, 32'h0, 2'b01);
        tick();
        chk("B skid ready", {rdy32, rdy64}, 2'b00);
        drive(32'h00300093, 32'h0, 2'b01);
        tick();
        chk("A held inst", inst32[31:0], 32'h00100093);
        chk("A held imm", imm32[31:0], 32'h1);
        chk("C held ready", rdy32, 1'b0);
        out_ready_i = 1'b1;
        tick();
        chk("B out", {vld32, inst32[31:0]}, {1'b1, 32'h00200093});
        chk("B imm", imm32[31:0], 32'h2);
        tick();
        chk("C out", {vld32, inst32[31:0]}, {1'b1, 32'h00300093});
        chk("C imm", imm64[63:0], 64'h3);
        in_valid_i = 1'b0;
        tick();
        chk("drained", vld32, 1'b0);

        // flush with the skid full and a bundle offered
        out_ready_i = 1'b0;
        drive(32'h00400093, 32'h0, 2'b01);
        tick();
        drive(32'h00500093, 32'h0, 2'b01);
        tick();
        chk("pre-flush ready", rdy32, 1'b0);
        drive(32'h00600093, 32'h0, 2'b01);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("flush valid", {vld32, vld64}, 2'b00);
        chk("flush ready", {rdy32, rdy64}, 2'b11);
        // a bundle accepted in the flush cycle must also be dropped
        drive(32'h00700093, 32'h0, 2'b01);
        flush_i = 1'b1;
        tick();
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        chk("flush drop valid", vld32, 1'b0);
        tick();
        tick();
        chk("flush stays empty", {vld32, vld64}, 2'b00);

        // asynchronous reset mid-operation
        out_ready_i = 1'b0;
        drive(32'hFFF00093, 32'h0, 2'b01);
        tick();
        in_valid_i = 1'b0;
        chk("pre-reset valid", vld32, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst valid", {vld32, vld64}, 2'b00);
        chk("async rst ready", {rdy32, rdy64}, 2'b11);
        chk("async rst imm", imm32, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
